regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between N_REQ writeback requesters, for example the ALU, the load unit and the multiply/divide unit of one core.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants at most one requester per cycle.
- The granted write is registered and driven onto the register file's wr / addr_wr / data_wr pins one cycle later.
- Writes to r0 are acknowledged but never issued to the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_rr.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants for the register-file writeback path, plus a small
// modulo-increment helper used by the round-robin pointer.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int N_WB_PORTS = 3;

    // Writeback port indices within the requester vectors
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

    // (idx + 1) mod n, without a divider
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: holds the rotating priority pointer and picks the first
// active request at or after the pointer, wrapping around. Grant is
// combinational; the pointer only moves when the parent reports a transfer.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [PTR_W-1:0] advance_idx,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_reg;
    logic             found;
    int               idx;

    // Masked-priority select: scan N slots starting at the pointer
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Pointer moves to the slot just past the winner, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= PTR_W'(wrap_inc(int'(advance_idx), N));
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between N_REQ writeback
// requesters. One requester is granted per non-stalled cycle; its write is
// registered and presented to the register file on the following cycle.
// Writes to r0 are acknowledged but never strobed.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int N_REQ  = N_WB_PORTS,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic                    rf_wr,
    output logic [ADDR_W-1:0]       rf_addr_wr,
    output logic [DATA_W-1:0]       rf_data_wr,
    output logic [PTR_W-1:0]        rr_ptr_o
);

    logic [N_REQ-1:0]  arb_req;
    logic [N_REQ-1:0]  arb_grant;
    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic [PTR_W-1:0]  sel_idx;
    logic              transfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              rf_wr_reg;
    logic [ADDR_W-1:0] rf_addr_reg;
    logic [DATA_W-1:0] rf_data_reg;

    // Unpack the flattened requester buses into per-port arrays
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Stall and reset hide all requests, so nothing is granted in those cycles
    assign arb_req = (stall || rst) ? '0 : req_valid;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (arb_req),
        .advance     (transfer),
        .advance_idx (sel_idx),
        .grant       (arb_grant),
        .ptr         (rr_ptr_o)
    );

    assign req_ready = arb_grant;
    assign transfer  = |arb_grant;

    // One-hot grant to index of the winning requester
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_idx = PTR_W'(i);
            end
        end
    end

    assign sel_addr = addr_arr[sel_idx];
    assign sel_data = data_arr[sel_idx];

    // Output register: capture the winner, suppress r0, hold everything on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_reg   <= 1'b0;
            rf_addr_reg <= '0;
            rf_data_reg <= '0;
        end else if (!stall) begin
            if (transfer && (sel_addr != '0)) begin
                rf_wr_reg   <= 1'b1;
                rf_addr_reg <= sel_addr;
                rf_data_reg <= sel_data;
            end else begin
                rf_wr_reg   <= 1'b0;
            end
        end
    end

    assign rf_wr      = rf_wr_reg;
    assign rf_addr_wr = rf_addr_reg;
    assign rf_data_wr = rf_data_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (N_REQ=3, DATA_W=32, ADDR_W=5).
// Inputs change 1ns after a rising edge; outputs are checked 1ns later
// (combinational ready) or 1ns after the next rising edge (registered).
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rf_wr;
    logic [4:0]  rf_addr_wr;
    logic [31:0] rf_data_wr;
    logic [1:0]  rr_ptr_o;

    int checks;
    int errors;

    regfile_wb_arbiter #(
        .DATA_W (32),
        .ADDR_W (5),
        .N_REQ  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rf_wr      (rf_wr),
        .rf_addr_wr (rf_addr_wr),
        .rf_data_wr (rf_data_wr),
        .rr_ptr_o   (rr_ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; req_valid = 3'b111;
        req_addr = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_in_rst got %b exp 000", req_ready); end
        req_valid = 3'b000;
        rst = 1'b0;
        #1;
        checks++;
        if (rf_wr !== 1'b0) begin errors++; $display("FAIL reset_rf_wr got %b exp 0", rf_wr); end
        checks++;
        if (rf_addr_wr !== 5'd0) begin errors++; $display("FAIL reset_rf_addr got %0d exp 0", rf_addr_wr); end
        checks++;
        if (rf_data_wr !== 32'd0) begin errors++; $display("FAIL reset_rf_data got %h exp 0", rf_data_wr); end
        checks++;
        if (rr_ptr_o !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", rr_ptr_o); end
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_idle got %b exp 000", req_ready); end
        $display("test_reset done: rf_wr=%b addr=%0d data=%h ptr=%0d", rf_wr, rf_addr_wr, rf_data_wr, rr_ptr_o);
        next_edge();
    endtask

    task automatic test_single();
        set_req(1, 5'd7, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", req_ready); end
        next_edge();
        req_valid = 3'b000;
        checks++;
        if (rf_wr !== 1'b1) begin errors++; $display("FAIL single_rf_wr got %b exp 1", rf_wr); end
        checks++;
        if (rf_addr_wr !== 5'd7) begin errors++; $display("FAIL single_rf_addr got %0d exp 7", rf_addr_wr); end
        checks++;
        if (rf_data_wr !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf_data got %h exp deadbeef", rf_data_wr); end
        checks++;
        if (rr_ptr_o !== 2'd2) begin errors++; $display("FAIL single_ptr got %0d exp 2", rr_ptr_o); end
        $display("test_single: req1 addr=7 -> rf_wr=%b addr=%0d data=%h ptr=%0d", rf_wr, rf_addr_wr, rf_data_wr, rr_ptr_o);
        next_edge();
        checks++;
        if (rf_wr !== 1'b0) begin errors++; $display("FAIL idle_rf_wr got %b exp 0", rf_wr); end
        checks++;
        if (rf_addr_wr !== 5'd7) begin errors++; $display("FAIL idle_addr_hold got %0d exp 7", rf_addr_wr); end
        $display("test_single idle: rf_wr=%b addr=%0d", rf_wr, rf_addr_wr);
    endtask

    // Pointer is 2 on entry, so the rotation is 2,0,1,2,0,1
    task automatic test_round_robin();
        logic [2:0]  exp_grant [6];
        logic [4:0]  exp_addr  [6];
        logic [31:0] exp_data  [6];
        exp_grant = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_addr  = '{5'd5, 5'd3, 5'd4, 5'd5, 5'd3, 5'd4};
        exp_data  = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0101,
                      32'h0000_0102, 32'h0000_0100, 32'h0000_0101};
        set_req(0, 5'd3, 32'h0000_0100);
        set_req(1, 5'd4, 32'h0000_0101);
        set_req(2, 5'd5, 32'h0000_0102);
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            #1;
            checks++;
            if (req_ready !== exp_grant[t]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", t, req_ready, exp_grant[t]); end
            next_edge();
            checks++;
            if (rf_wr !== 1'b1) begin errors++; $display("FAIL rr_rf_wr[%0d] got %b exp 1", t, rf_wr); end
            checks++;
            if (rf_addr_wr !== exp_addr[t]) begin errors++; $display("FAIL rr_addr[%0d] got %0d exp %0d", t, rf_addr_wr, exp_addr[t]); end
            checks++;
            if (rf_data_wr !== exp_data[t]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", t, rf_data_wr, exp_data[t]); end
            $display("test_round_robin[%0d]: rf_wr=%b addr=%0d data=%h", t, rf_wr, rf_addr_wr, rf_data_wr);
        end
        req_valid = 3'b000;
        checks++;
        if (rr_ptr_o !== 2'd2) begin errors++; $display("FAIL rr_ptr_end got %0d exp 2", rr_ptr_o); end
    endtask

    task automatic test_r0();
        set_req(0, 5'd0, 32'h0000_1234);
        req_valid = 3'b001;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL r0_ready got %b exp 001", req_ready); end
        next_edge();
        req_valid = 3'b000;
        checks++;
        if (rf_wr !== 1'b0) begin errors++; $display("FAIL r0_rf_wr got %b exp 0", rf_wr); end
        checks++;
        if (rr_ptr_o !== 2'd1) begin errors++; $display("FAIL r0_ptr got %0d exp 1", rr_ptr_o); end
        $display("test_r0: rf_wr=%b ptr=%0d", rf_wr, rr_ptr_o);
    endtask

    task automatic test_stall();
        set_req(1, 5'd6, 32'h0000_0066);
        req_valid = 3'b010;
        next_edge();
        set_req(2, 5'd11, 32'hCAFE_0002);
        req_valid = 3'b100;
        stall = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            checks++;
            if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 000", t, req_ready); end
            next_edge();
            checks++;
            if (rf_wr !== 1'b1) begin errors++; $display("FAIL stall_rf_wr[%0d] got %b exp 1", t, rf_wr); end
            checks++;
            if (rf_addr_wr !== 5'd6) begin errors++; $display("FAIL stall_addr[%0d] got %0d exp 6", t, rf_addr_wr); end
            checks++;
            if (rf_data_wr !== 32'h0000_0066) begin errors++; $display("FAIL stall_data[%0d] got %h exp 66", t, rf_data_wr); end
            checks++;
            if (rr_ptr_o !== 2'd2) begin errors++; $display("FAIL stall_ptr[%0d] got %0d exp 2", t, rr_ptr_o); end
            $display("test_stall[%0d]: ready=%b rf_wr=%b addr=%0d ptr=%0d", t, req_ready, rf_wr, rf_addr_wr, rr_ptr_o);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b100) begin errors++; $display("FAIL unstall_ready got %b exp 100", req_ready); end
        next_edge();
        req_valid = 3'b000;
        checks++;
        if (rf_wr !== 1'b1) begin errors++; $display("FAIL unstall_rf_wr got %b exp 1", rf_wr); end
        checks++;
        if (rf_addr_wr !== 5'd11) begin errors++; $display("FAIL unstall_addr got %0d exp 11", rf_addr_wr); end
        checks++;
        if (rf_data_wr !== 32'hCAFE_0002) begin errors++; $display("FAIL unstall_data got %h exp cafe0002", rf_data_wr); end
        checks++;
        if (rr_ptr_o !== 2'd0) begin errors++; $display("FAIL unstall_ptr got %0d exp 0", rr_ptr_o); end
        $display("test_stall release: rf_wr=%b addr=%0d data=%h ptr=%0d", rf_wr, rf_addr_wr, rf_data_wr, rr_ptr_o);
    endtask

    task automatic test_reset_mid();
        set_req(0, 5'd9, 32'h0000_0099);
        req_valid = 3'b001;
        next_edge();
        req_valid = 3'b000;
        checks++;
        if (rf_wr !== 1'b1 || rr_ptr_o !== 2'd1) begin errors++; $display("FAIL mid_pre_rst got wr=%b ptr=%0d exp wr=1 ptr=1", rf_wr, rr_ptr_o); end
        rst = 1'b1;
        #1;
        checks++;
        if (rf_wr !== 1'b0) begin errors++; $display("FAIL mid_async_rf_wr got %b exp 0", rf_wr); end
        checks++;
        if (rf_addr_wr !== 5'd0) begin errors++; $display("FAIL mid_async_addr got %0d exp 0", rf_addr_wr); end
        next_edge();
        rst = 1'b0;
        req_valid = 3'b111;
        #1;
        checks++;
        if (rr_ptr_o !== 2'd0) begin errors++; $display("FAIL mid_ptr got %0d exp 0", rr_ptr_o); end
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_ready got %b exp 001", req_ready); end
        $display("test_reset_mid: rf_wr=%b ptr=%0d ready=%b", rf_wr, rr_ptr_o, req_ready);
        req_valid = 3'b000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_r0();
        test_stall();
        test_reset_mid();
        next_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
